// File: rtl/sv32_page_table_walker_pkg.sv
// Shared types and helpers for the SV32 page-table walker.
// Holds the walker state encoding, PTE flag bit positions and the PTE address helper.
package sv32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD0,
    DONE,
    DRAIN
  } walk_state_e;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam logic [31:0] PTE_FAULT = 32'h0;
  localparam logic [1:0]  PRIV_USER = 2'b00;

  // Physical address of the PTE selected by vpn10 within the table at ppn22.
  function automatic logic [33:0] pte_addr(input logic [21:0] ppn22, input logic [9:0] vpn10);
    return {ppn22, 12'h000} + {22'h0, vpn10, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_page_table_walker_pte_check.sv
// Combinational PTE checker: classifies a raw PTE at level 1 or 0 and builds
// the normalised leaf word, which is already PTE_FAULT whenever fault is set.
module sv32_pte_check
  import sv32_pkg::*;
#(
  parameter bit CHECK_A = 1'b1
) (
  input  logic [31:0] rdata,
  input  logic        level,
  input  logic [9:0]  vpn0,
  output logic        is_leaf,
  output logic        fault,
  output logic [31:0] leaf_pte
);

  always_comb begin
    is_leaf  = rdata[PTE_R] | rdata[PTE_X];
    fault    = 1'b0;
    leaf_pte = PTE_FAULT;

    if (!rdata[PTE_V] || (!rdata[PTE_R] && rdata[PTE_W])) begin
      fault = 1'b1;
    end
    if (is_leaf && CHECK_A && !rdata[PTE_A]) begin
      fault = 1'b1;
    end

    // A level-1 pointer may reference any 34-bit address; only leaves are range-checked.
    if (level) begin
      if (is_leaf && ((rdata[19:10] != 10'h0) || (rdata[31:30] != 2'b00))) begin
        fault = 1'b1;
      end
    end else begin
      if (!is_leaf || (rdata[31:30] != 2'b00)) begin
        fault = 1'b1;
      end
    end

    if (!fault) begin
      if (level) begin
        leaf_pte = {rdata[29:20], vpn0, 2'b00, rdata[9:0]};
      end else begin
        leaf_pte = {rdata[29:10], 2'b00, rdata[9:0]};
      end
    end
  end

endmodule

// File: rtl/sv32_page_table_walker.sv
// SV32 page-table walker: performs up to two PTE reads for the instruction
// translator and returns a normalised leaf word, or zero on any fault.
module sv32_page_table_walker
  import sv32_pkg::*;
#(
  parameter bit CHECK_A = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] satp,
  input  logic [1:0]  privilege_mode,
  input  logic        walk_valid,
  output logic        walk_ready,
  output logic [31:0] pte,
  input  logic        abort,
  output logic        mem_valid,
  output logic [33:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  walk_state_e state_q, state_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic [31:0] pte_q, pte_d;
  logic [33:0] mem_addr_q, mem_addr_d;

  logic        chk_level;
  logic        chk_leaf;
  logic        chk_fault;
  logic [31:0] chk_pte;
  logic [9:0]  bare_flags;
  logic        unused_inputs;

  assign unused_inputs = ^{satp[30:22], address[11:0]};

  assign chk_level = (state_q == RD1);

  sv32_pte_check #(
    .CHECK_A (CHECK_A)
  ) u_pte_check (
    .rdata    (mem_rdata),
    .level    (chk_level),
    .vpn0     (vpn0_q),
    .is_leaf  (chk_leaf),
    .fault    (chk_fault),
    .leaf_pte (chk_pte)
  );

  always_comb begin
    state_d    = state_q;
    vpn0_d     = vpn0_q;
    pte_d      = pte_q;
    mem_addr_d = mem_addr_q;

    bare_flags        = 10'h0;
    bare_flags[PTE_V] = 1'b1;
    bare_flags[PTE_R] = 1'b1;
    bare_flags[PTE_W] = 1'b1;
    bare_flags[PTE_X] = 1'b1;
    bare_flags[PTE_U] = (privilege_mode == PRIV_USER);
    bare_flags[PTE_G] = 1'b0;
    bare_flags[PTE_A] = 1'b1;
    bare_flags[PTE_D] = 1'b1;

    case (state_q)
      IDLE: begin
        if (walk_valid && !abort) begin
          vpn0_d = address[21:12];
          if (!satp[31]) begin
            pte_d   = {address[31:12], 2'b00, bare_flags};
            state_d = DONE;
          end else begin
            mem_addr_d = pte_addr(satp[21:0], address[31:22]);
            state_d    = RD1;
          end
        end
      end
      RD1, RD0: begin
        if (mem_ready) begin
          if (abort) begin
            state_d = IDLE;
          end else if (chk_fault || chk_leaf || (state_q == RD0)) begin
            pte_d   = chk_pte;
            state_d = DONE;
          end else begin
            mem_addr_d = pte_addr(mem_rdata[31:10], vpn0_q);
            state_d    = RD0;
          end
        end else if (abort) begin
          // The outstanding read cannot be withdrawn, so wait for it and drop the data.
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      vpn0_q     <= 10'h0;
      pte_q      <= PTE_FAULT;
      mem_addr_q <= 34'h0;
    end else begin
      state_q    <= state_d;
      vpn0_q     <= vpn0_d;
      pte_q      <= pte_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign walk_ready = (state_q == DONE);
  assign mem_valid  = (state_q == RD1) || (state_q == RD0) || (state_q == DRAIN);
  assign mem_addr   = mem_addr_q;
  assign pte        = pte_q;

endmodule

// File: tb/tb_sv32_page_table_walker.sv
// Scoreboard bench for sv32_page_table_walker: a behavioural walk model queues the
// expected leaf word, read addresses, read count and latency for each request.
module tb_sv32_page_table_walker;

  logic        clk;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] satp;
  logic [1:0]  privilege_mode;
  logic        walk_valid;
  logic        walk_ready;
  logic [31:0] pte;
  logic        abort;
  logic        mem_valid;
  logic [33:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] pte;
    logic [33:0] addr0;
    logic [33:0] addr1;
    int          reads;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] last_pte;

  sv32_page_table_walker #(
    .CHECK_A (1'b1)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .address        (address),
    .satp           (satp),
    .privilege_mode (privilege_mode),
    .walk_valid     (walk_valid),
    .walk_ready     (walk_ready),
    .pte            (pte),
    .abort          (abort),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pte_ok(input logic [31:0] p);
    bit leaf;
    leaf = p[1] | p[3];
    return p[0] && !(!p[1] && p[2]) && !(leaf && !p[6]);
  endfunction

  // Reference walk following the architectural rules directly.
  function automatic exp_t model(input logic [31:0] va, input logic [31:0] sp, input logic [1:0] pv,
                                 input logic [31:0] l1, input logic [31:0] l0, input int waits);
    exp_t e;
    logic [7:0] flags;
    e.addr0 = {sp[21:0], 12'h000} + {22'h0, va[31:22], 2'b00};
    e.addr1 = {l1[31:10], 12'h000} + {22'h0, va[21:12], 2'b00};
    e.pte   = 32'h0;
    e.reads = 0;
    if (!sp[31]) begin
      flags = (pv == 2'b00) ? 8'hDF : 8'hCF;
      e.pte = {va[31:12], 4'h0, flags};
    end else begin
      e.reads = 1;
      if (pte_ok(l1) && (l1[1] | l1[3])) begin
        if (l1[19:10] == 10'h0 && l1[31:30] == 2'b00)
          e.pte = {l1[29:20], va[21:12], 2'b00, l1[9:0]};
      end else if (pte_ok(l1)) begin
        e.reads = 2;
        if (pte_ok(l0) && (l0[1] | l0[3]) && l0[31:30] == 2'b00)
          e.pte = {l0[29:10], 2'b00, l0[9:0]};
      end
    end
    e.lat = 1 + e.reads * (waits + 1);
    return e;
  endfunction

  // Issues one walk, serves its memory reads with the given wait states and scores the result.
  task automatic applyStimulus(input string tag, input logic [31:0] va, input logic [31:0] sp,
                               input logic [1:0] pv, input logic [31:0] l1, input logic [31:0] l0,
                               input int waits);
    exp_t e;
    exp_t got_e;
    int   cycles;
    int   reads;
    int   wcnt;
    bit   seen;
    e = model(va, sp, pv, l1, l0, waits);
    exp_q.push_back(e);
    address = va; satp = sp; privilege_mode = pv; walk_valid = 1'b1;
    @(negedge clk);
    walk_valid = 1'b0;
    cycles = 1; reads = 0; wcnt = 0; seen = 1'b0;
    while (!seen && cycles < 100) begin
      if (walk_ready) begin
        seen = 1'b1;
      end else begin
        if (mem_valid) begin
          if (reads < 2)
            checkOutput({tag, " mem_addr"}, 64'(mem_addr), 64'((reads == 0) ? e.addr0 : e.addr1));
          if (wcnt == waits) begin
            mem_ready = 1'b1;
            mem_rdata = (reads == 0) ? l1 : l0;
            reads++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        cycles++;
      end
    end
    if (!seen) checkOutput({tag, " timeout"}, 64'(0), 64'(1));
    got_e = exp_q.pop_front();
    checkOutput({tag, " pte"}, 64'(pte), 64'(got_e.pte));
    checkOutput({tag, " reads"}, 64'(reads), 64'(got_e.reads));
    checkOutput({tag, " latency"}, 64'(cycles), 64'(got_e.lat));
    last_pte = got_e.pte;
    @(negedge clk);
    checkOutput({tag, " pulse_width"}, 64'(walk_ready), 64'(0));
  endtask

  // Aborts a walk in RD1, either while the read is pending or on its completion cycle.
  task automatic abortWalk(input string tag, input logic [31:0] va, input logic [31:0] sp,
                           input bit coincident);
    logic [33:0] a1;
    a1 = {sp[21:0], 12'h000} + {22'h0, va[31:22], 2'b00};
    address = va; satp = sp; privilege_mode = 2'b00; walk_valid = 1'b1;
    @(negedge clk);
    walk_valid = 1'b0;
    checkOutput({tag, " rd1 mem_valid"}, 64'(mem_valid), 64'(1));
    checkOutput({tag, " rd1 mem_addr"}, 64'(mem_addr), 64'(a1));
    abort = 1'b1;
    if (coincident) begin
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_2001;
      @(negedge clk);
      abort = 1'b0; mem_ready = 1'b0;
    end else begin
      @(negedge clk);
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
        checkOutput({tag, " drain mem_valid"}, 64'(mem_valid), 64'(1));
        checkOutput({tag, " drain mem_addr"}, 64'(mem_addr), 64'(a1));
        checkOutput({tag, " drain walk_ready"}, 64'(walk_ready), 64'(0));
        @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_00CF;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    checkOutput({tag, " idle mem_valid"}, 64'(mem_valid), 64'(0));
    checkOutput({tag, " no walk_ready"}, 64'(walk_ready), 64'(0));
    checkOutput({tag, " pte held"}, 64'(pte), 64'(last_pte));
    @(negedge clk);
    checkOutput({tag, " still no walk_ready"}, 64'(walk_ready), 64'(0));
  endtask

  // Pulses resetn while RD0 is waiting on a slow read.
  task automatic resetDuringWalk(input string tag, input logic [31:0] va, input logic [31:0] sp,
                                 input logic [31:0] l1);
    logic [33:0] a2;
    a2 = {l1[31:10], 12'h000} + {22'h0, va[21:12], 2'b00};
    address = va; satp = sp; privilege_mode = 2'b00; walk_valid = 1'b1;
    @(negedge clk);
    walk_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = l1;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput({tag, " rd0 mem_valid"}, 64'(mem_valid), 64'(1));
    checkOutput({tag, " rd0 mem_addr"}, 64'(mem_addr), 64'(a2));
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput({tag, " walk_ready"}, 64'(walk_ready), 64'(0));
    checkOutput({tag, " pte"}, 64'(pte), 64'(0));
    checkOutput({tag, " mem_valid"}, 64'(mem_valid), 64'(0));
    checkOutput({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    last_pte = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; last_pte = 32'h0;
    clk = 1'b0; resetn = 1'b0;
    address = 32'h0; satp = 32'h0; privilege_mode = 2'b00;
    walk_valid = 1'b0; abort = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    checkOutput("reset walk_ready", 64'(walk_ready), 64'(0));
    checkOutput("reset pte", 64'(pte), 64'(0));
    checkOutput("reset mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus("bare_user",  32'h1234_5678, 32'h0000_0000, 2'b00, 32'h0, 32'h0, 0);
    applyStimulus("bare_super", 32'hFFFF_FABC, 32'h0000_0010, 2'b01, 32'h0, 32'h0, 0);
    applyStimulus("two_level",  32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0300_00CB, 0);
    applyStimulus("superpage",  32'h00C0_5000, 32'h8000_0010, 2'b00, 32'h0040_00CF, 32'h0, 0);
    applyStimulus("sp_misalign",32'h00C0_5000, 32'h8000_0010, 2'b00, 32'h0040_04CF, 32'h0, 0);
    applyStimulus("sp_high_pa", 32'h00C0_5000, 32'h8000_0010, 2'b00, 32'h4000_00CF, 32'h0, 0);
    applyStimulus("l1_invalid", 32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_0000, 32'h0, 0);
    applyStimulus("l1_w_only",  32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_0005, 32'h0, 0);
    applyStimulus("l1_no_a",    32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_000B, 32'h0, 0);
    applyStimulus("l0_w_only",  32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0000_2005, 0);
    applyStimulus("l0_no_a",    32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0000_400B, 0);
    applyStimulus("l0_nonleaf", 32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0000_3001, 0);
    applyStimulus("l0_high_pa", 32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'hC000_00CF, 0);
    applyStimulus("max_root",   32'hFFC0_0000, 32'h803F_FFFF, 2'b00, 32'hFFFF_FC01, 32'h3FFF_FCDF, 0);
    applyStimulus("wait3",      32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0300_00CB, 3);

    abortWalk("abort_drain", 32'h0040_1ABC, 32'h8000_0010, 1'b0);
    applyStimulus("after_drain", 32'h1357_9000, 32'h8000_0020, 2'b00, 32'h0001_0001, 32'h0000_04CF, 1);
    abortWalk("abort_coinc", 32'h0040_1ABC, 32'h8000_0010, 1'b1);
    applyStimulus("after_coinc", 32'h00C0_5000, 32'h8000_0010, 2'b00, 32'h0040_00CF, 32'h0, 0);

    resetDuringWalk("reset_rd0", 32'h0040_1ABC, 32'h8000_0010, 32'h0000_2001);
    applyStimulus("after_reset", 32'h0040_1ABC, 32'h8000_0010, 2'b00, 32'h0000_2001, 32'h0300_00CB, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
